// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: refill FSM state encoding and PC mux selects.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] PC_SEL_NEXT     = 2'b00;
    localparam logic [1:0] PC_SEL_RECOVERY = 2'b01;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the optional fetch performance counters.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_aL,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Fetch-stage controller: PC update, FIFO enqueue gating and icache miss refill.
// Define FETCH_CTRL_PERF_EN to build the miss_count / stall_cycles counters.
module icache_refill_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int NUM_OFFSET_BITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_aL,
    input  logic [ADDR_WIDTH-1:0] PC,
    input  logic                  icache_hit,
    input  logic                  ififo_ready_enq,
    input  logic                  backend_stall,
    input  logic                  recovery_PC_valid,
    input  logic                  dram_req_ready,
    input  logic                  dram_response_valid,
    output logic [1:0]            pc_sel,
    output logic                  pc_we,
    output logic                  ififo_valid_enq,
    output logic                  icache_we,
    output logic                  dram_req_valid,
    output logic [ADDR_WIDTH-1:0] dram_req_addr
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]           miss_count,
    output logic [31:0]           stall_cycles
`endif
);

    // Handshake: a refill request transfers on a cycle where dram_req_valid and
    // dram_req_ready are both high; valid and address hold until that cycle.
    // dram_response_valid is a one-cycle pulse and is never back-pressured.

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] dram_req_addr_q, dram_req_addr_d;
    logic                  fetch_ok;

    assign fetch_ok = icache_hit && ififo_ready_enq && !backend_stall;

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state_q         <= RUN;
            dram_req_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            dram_req_addr_q <= dram_req_addr_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        dram_req_addr_d = dram_req_addr_q;
        case (state_q)
            RUN: begin
                if (!recovery_PC_valid && !fetch_ok && !icache_hit) begin
                    state_d         = REQ;
                    dram_req_addr_d = {PC[ADDR_WIDTH-1:NUM_OFFSET_BITS], {NUM_OFFSET_BITS{1'b0}}};
                end
            end
            REQ: begin
                // A request already accepted alongside a recovery leaves an orphan response.
                if (recovery_PC_valid) begin
                    state_d = dram_req_ready ? DRAIN : RUN;
                end else if (dram_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (dram_response_valid) begin
                    state_d = RUN;
                end else if (recovery_PC_valid) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (dram_response_valid) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_sel          = PC_SEL_NEXT;
        pc_we           = 1'b0;
        ififo_valid_enq = 1'b0;
        icache_we       = 1'b0;
        dram_req_valid  = 1'b0;
        if (rst_aL) begin
            if (recovery_PC_valid) begin
                pc_sel = PC_SEL_RECOVERY;
                pc_we  = 1'b1;
            end
            case (state_q)
                RUN: begin
                    if (!recovery_PC_valid && fetch_ok) begin
                        ififo_valid_enq = 1'b1;
                        pc_we           = 1'b1;
                    end
                end
                REQ:  dram_req_valid = 1'b1;
                // PC is still the miss PC in this cycle even if a recovery loads it.
                WAIT: icache_we = dram_response_valid;
                default: ;
            endcase
        end
    end

    assign dram_req_addr = dram_req_addr_q;

`ifdef FETCH_CTRL_PERF_EN
    logic miss_inc;
    logic stall_inc;

    assign miss_inc  = (state_q == RUN) && (state_d == REQ);
    assign stall_inc = (state_q != RUN) || (icache_hit && !ififo_ready_enq);

    sat_counter #(.WIDTH(32)) u_miss_cnt (
        .clk    (clk),
        .rst_aL (rst_aL),
        .inc    (miss_inc),
        .count  (miss_count)
    );

    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk    (clk),
        .rst_aL (rst_aL),
        .inc    (stall_inc),
        .count  (stall_cycles)
    );
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: single-cycle RUN vector table plus
// hand-written miss, recovery and reset sequences.
module tb_icache_refill_ctrl;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_aL = 1'b0;
    logic [31:0] PC = '0;
    logic        icache_hit = 1'b0;
    logic        ififo_ready_enq = 1'b0;
    logic        backend_stall = 1'b0;
    logic        recovery_PC_valid = 1'b0;
    logic        dram_req_ready = 1'b0;
    logic        dram_response_valid = 1'b0;
    logic [1:0]  pc_sel;
    logic        pc_we;
    logic        ififo_valid_enq;
    logic        icache_we;
    logic        dram_req_valid;
    logic [31:0] dram_req_addr;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] miss_count;
    logic [31:0] stall_cycles;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    icache_refill_ctrl #(.ADDR_WIDTH(32), .NUM_OFFSET_BITS(3)) dut (
        .clk                 (clk),
        .rst_aL              (rst_aL),
        .PC                  (PC),
        .icache_hit          (icache_hit),
        .ififo_ready_enq     (ififo_ready_enq),
        .backend_stall       (backend_stall),
        .recovery_PC_valid   (recovery_PC_valid),
        .dram_req_ready      (dram_req_ready),
        .dram_response_valid (dram_response_valid),
        .pc_sel              (pc_sel),
        .pc_we               (pc_we),
        .ififo_valid_enq     (ififo_valid_enq),
        .icache_we           (icache_we),
        .dram_req_valid      (dram_req_valid),
        .dram_req_addr       (dram_req_addr)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .miss_count          (miss_count),
        .stall_cycles        (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv, hit, renq, stall;
        logic [31:0] pc;
        logic [1:0]  e_sel;
        logic        e_we, e_enq;
        state_t      e_nxt;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] sel, input logic we,
                           input logic enq, input logic iwe, input logic rvld);
        chk({tag, ".pc_sel"}, 32'(pc_sel), 32'(sel));
        chk({tag, ".pc_we"}, 32'(pc_we), 32'(we));
        chk({tag, ".enq"}, 32'(ififo_valid_enq), 32'(enq));
        chk({tag, ".icache_we"}, 32'(icache_we), 32'(iwe));
        chk({tag, ".req_valid"}, 32'(dram_req_valid), 32'(rvld));
    endtask

    task automatic chk_state(input string tag, input state_t exp);
        chk({tag, ".state"}, 32'(dut.state_q), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        icache_hit          = 1'b1;
        ififo_ready_enq     = 1'b0;
        backend_stall       = 1'b0;
        recovery_PC_valid   = 1'b0;
        dram_req_ready      = 1'b0;
        dram_response_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_aL = 1'b0;
        clear_in();
        step();
        step();
        rst_aL = 1'b1;
    endtask

    // From RUN: miss at pc, request accepted at once, lands in WAIT.
    task automatic goto_wait(input logic [31:0] pc);
        PC = pc;
        icache_hit = 1'b0;
        step();
        dram_req_ready = 1'b1;
        step();
        dram_req_ready = 1'b0;
        chk_state("goto_wait", WAIT);
    endtask

    initial begin
        //          rv    hit   renq  stall pc            sel   we    enq   next
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 2'b01, 1'b1, 1'b0, RUN};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0104, 2'b00, 1'b1, 1'b1, RUN};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0108, 2'b00, 1'b0, 1'b0, RUN};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_010C, 2'b00, 1'b0, 1'b0, RUN};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_2037, 2'b00, 1'b0, 1'b0, REQ};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_3000, 2'b01, 1'b1, 1'b0, RUN};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0, REQ};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_4444, 2'b01, 1'b1, 1'b0, RUN};

        // Reset: enables forced low even with a live recovery request.
        rst_aL = 1'b0;
        clear_in();
        recovery_PC_valid = 1'b1;
        #1;
        chk_out("reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.addr", dram_req_addr, 32'h0);
        chk_state("reset", RUN);
        step();
        rst_aL = 1'b1;
        clear_in();

        for (int i = 0; i < 8; i++) begin
            recovery_PC_valid = tbl[i].rv;
            icache_hit        = tbl[i].hit;
            ififo_ready_enq   = tbl[i].renq;
            backend_stall     = tbl[i].stall;
            PC                = tbl[i].pc;
            #1;
            chk_out($sformatf("tbl%0d", i), tbl[i].e_sel, tbl[i].e_we, tbl[i].e_enq, 1'b0, 1'b0);
            step();
            chk_state($sformatf("tbl%0d", i), tbl[i].e_nxt);
            if (tbl[i].e_nxt == REQ) begin
                chk($sformatf("tbl%0d.addr", i), dram_req_addr, tbl[i].pc & 32'hFFFF_FFF8);
                clear_in();
                recovery_PC_valid = 1'b1;
                step();
                clear_in();
            end
        end

        // Hit stream, then FIFO full.
        do_reset();
        icache_hit = 1'b1;
        ififo_ready_enq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            PC = 32'h0000_0200 + 32'(i * 4);
            #1;
            chk_out($sformatf("stream%0d", i), 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
            step();
        end
        ififo_ready_enq = 1'b0;
        #1;
        chk_out("full", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Full miss: request held 3 cycles, response after 5 WAIT cycles, replay.
        do_reset();
        PC = 32'h0000_104C;
        icache_hit = 1'b0;
        ififo_ready_enq = 1'b1;
        #1;
        chk_out("miss_det", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            dram_req_ready = (i == 2);
            #1;
            chk_out($sformatf("req%0d", i), 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
            chk($sformatf("req%0d.addr", i), dram_req_addr, 32'h0000_1048);
            step();
        end
        dram_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dram_response_valid = (i == 4);
            #1;
            chk_state($sformatf("wait%0d", i), WAIT);
            chk_out($sformatf("wait%0d", i), 2'b00, 1'b0, 1'b0, (i == 4), 1'b0);
            step();
        end
        dram_response_valid = 1'b0;
        icache_hit = 1'b1;
        #1;
        chk_state("replay", RUN);
        chk_out("replay", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef FETCH_CTRL_PERF_EN
        chk("miss_count", miss_count, 32'd1);
        chk("stall_cycles", stall_cycles, 32'd8);
`endif

        // Recovery in REQ before ready: request dropped, back to RUN.
        do_reset();
        PC = 32'h0000_5010;
        icache_hit = 1'b0;
        step();
        recovery_PC_valid = 1'b1;
        #1;
        chk_out("req_rcv", 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        clear_in();
        #1;
        chk_state("req_rcv_next", RUN);
        chk("req_rcv_next.req_valid", 32'(dram_req_valid), 32'd0);

        // Recovery in REQ with ready: request already taken, drain the orphan.
        do_reset();
        PC = 32'h0000_5020;
        icache_hit = 1'b0;
        step();
        recovery_PC_valid = 1'b1;
        dram_req_ready = 1'b1;
        step();
        clear_in();
        chk_state("req_rcv_rdy", DRAIN);

        // Recovery in WAIT: DRAIN swallows the response 3 cycles later.
        do_reset();
        goto_wait(32'h0000_6000);
        recovery_PC_valid = 1'b1;
        #1;
        chk_out("wait_rcv", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        clear_in();
        chk_state("drain0", DRAIN);
        recovery_PC_valid = 1'b1;
        ififo_ready_enq = 1'b1;
        #1;
        chk_out("drain_rcv", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        clear_in();
        chk_state("drain1", DRAIN);
        step();
        dram_response_valid = 1'b1;
        #1;
        chk_state("drain_resp", DRAIN);
        chk_out("drain_resp", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        clear_in();
        chk_state("drain_done", RUN);

        // Recovery and response together in WAIT.
        do_reset();
        goto_wait(32'h0000_7008);
        recovery_PC_valid = 1'b1;
        dram_response_valid = 1'b1;
        #1;
        chk_out("wait_both", 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        clear_in();
        chk_state("wait_both_next", RUN);

        // Asynchronous reset in the middle of WAIT.
        do_reset();
        goto_wait(32'h0000_8010);
        recovery_PC_valid = 1'b1;
        dram_response_valid = 1'b1;
        #2;
        rst_aL = 1'b0;
        #1;
        chk_out("async_rst", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("async_rst.addr", dram_req_addr, 32'h0);
        chk_state("async_rst", RUN);
`ifdef FETCH_CTRL_PERF_EN
        chk("async_rst.miss", miss_count, 32'd0);
        chk("async_rst.stall", stall_cycles, 32'd0);
`endif
        step();
        clear_in();
        rst_aL = 1'b1;
        step();
        chk_state("after_rst", RUN);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Fetch-stage controller sitting beside the PC register, instruction cache and instruction FIFO inside the IFU. It sequences every fetch cycle: it drives the PC mux select and PC write enable, and gates instruction-FIFO enqueue. On an icache miss it issues one block-aligned DRAM refill request and writes the returned block into the icache. Branch recovery can arrive at any point in a miss; the block handles it without ever writing a stale block into the cache.

## Interface
- ADDR_WIDTH, 32, PC/address width
- NUM_OFFSET_BITS, 3, byte-offset bits within an icache block; cleared to form `dram_req_addr`
- clk  in  1  clock
- rst_aL  in  1  asynchronous active-low reset
- PC  in  ADDR_WIDTH  current PC register value
- icache_hit  in  1  icache lookup hit for `PC`, same cycle
- ififo_ready_enq  in  1  instruction FIFO can accept an entry
- backend_stall  in  1  hold fetch
- recovery_PC_valid  in  1  redirect request; `recovery_PC` is muxed externally
- dram_req_ready  in  1  DRAM accepts request
- dram_response_valid  in  1  refill block valid, single-cycle pulse
- pc_sel  out  2  PC mux select: 2'b00 next_PC, 2'b01 recovery_PC; 2'b1x never driven
- pc_we  out  1  PC register write enable
- ififo_valid_enq  out  1  enqueue selected instruction
- icache_we  out  1  write `dram_response` into the icache at index/tag of `PC`
- dram_req_valid  out  1  refill request valid
- dram_req_addr  out  ADDR_WIDTH  registered miss address, offset bits zero
- miss_count  out  32  (FETCH_CTRL_PERF_EN only) refill requests issued
- stall_cycles  out  32  (FETCH_CTRL_PERF_EN only) cycles without enqueue, excluding backend_stall-only cycles

## Operation
- States: RUN, REQ, WAIT, DRAIN. Reset state is RUN.
- RUN:
  - Priority 1, `recovery_PC_valid`: pc_sel=01, pc_we=1, no enqueue.
  - Priority 2, hit & ififo_ready_enq & !backend_stall: ififo_valid_enq=1, pc_sel=00, pc_we=1.
  - Priority 3, !icache_hit: latch `PC` with offset bits cleared into `dram_req_addr`; go to REQ.
  - Otherwise: hold, pc_we=0.
- REQ:
  - dram_req_valid=1.
  - On dram_req_ready, go to WAIT.
  - If recovery occurs without ready: load the recovery PC, drop the request, go to RUN.
  - If recovery occurs with ready: load the recovery PC, go to DRAIN.
- WAIT:
  - pc_we=0, so `PC` keeps indexing the miss line.
  - On dram_response_valid: icache_we=1, go to RUN. The lookup replays and hits the next cycle.
  - If recovery occurs without a response: load the recovery PC, go to DRAIN.
  - If recovery and response occur in the same cycle: icache_we=1 (PC is still the miss PC this cycle) and the PC loads recovery; go to RUN.
- DRAIN:
  - Wait for the orphaned response; icache_we=0, and the response is discarded.
  - A recovery arriving here loads the PC and the block stays in DRAIN.
  - On the response, go to RUN.
- ififo_valid_enq=0 in all states other than RUN.
- At most one outstanding DRAM request at any time.

## Timing
- All outputs are combinational from state and inputs, except `dram_req_addr` and the counters, which are registered.
- Reset (async assert, sync release): state=RUN, dram_req_addr=0, counters=0.
- While rst_aL is low, all enables are 0 and pc_sel=00.
- Miss detected in cycle n → dram_req_valid in n+1.
- Response in cycle m → icache_we in m → hit and enqueue in m+1 at the earliest.
- Minimum miss penalty: 3 cycles (REQ, WAIT, replay).
- dram_req_valid stays high until accepted; `dram_req_addr` is stable while it is high.
- Reset mid-miss returns to RUN. The external DRAM model is reset together with the block, so there is no orphan handling.

## Configuration
- Macro `FETCH_CTRL_PERF_EN`, with the counters built from the saturating counter sub-module below.
- With the macro defined:
  - `miss_count` +1 on each RUN→REQ transition.
  - `stall_cycles` +1 each cycle in REQ/WAIT/DRAIN, or in RUN with hit & !ififo_ready_enq.
  - Both counters saturate at 32'hFFFF_FFFF.
- Without the macro: the ports and counter logic are absent and the control behaviour is identical.

## Structure
- Shared package `fetch_pkg`: state encoding (RUN/REQ/WAIT/DRAIN), PC_SEL_NEXT=2'b00, PC_SEL_RECOVERY=2'b01.
- Sub-module `sat_counter` (parameter WIDTH; ports clk, rst_aL, inc, count), instantiated twice under the macro.
- The FSM next-state and output logic stays in `icache_refill_ctrl`.

## Test plan
- Hit stream: hit=1, ready_enq=1 for 4 cycles → ififo_valid_enq=1 and pc_we=1 with pc_sel=00 each cycle. With ready_enq=0 → pc_we=0, no enqueue.
- Miss at PC=32'h0000_104C, dram_req_ready=1 after 2 cycles, response 5 cycles later:
  - dram_req_addr=32'h0000_1048 and dram_req_valid is held for 3 cycles.
  - icache_we=1 in the response cycle, then an enqueue the next cycle.
  - miss_count=1.
- Recovery in REQ before ready → dram_req_valid drops the next cycle, pc_sel=01 with pc_we=1, state RUN, no icache_we.
- Recovery in WAIT, response 3 cycles later → state DRAIN, icache_we stays 0 on the response, then back in RUN.
- Recovery and response in the same cycle in WAIT → icache_we=1, pc_sel=01, pc_we=1, next state RUN.
- rst_aL pulsed low mid-WAIT → all outputs 0 immediately, dram_req_addr=0, counters=0, state RUN after release.
